// File: rtl/uk_arb_pkg.sv
// Shared types and default sizes for the Uk coefficient ROM lookup arbiter.
package uk_arb_pkg;

  localparam int UK_NREQ   = 4;
  localparam int UK_AW     = 8;
  localparam int UK_DW     = 8;
  localparam int BURST_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/uk_rr_pick.sv
// Combinational round-robin picker: first requesting lane after rr_last, wrapping
// from NREQ-1 back to lane 0.
module uk_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_last,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    // rr_last itself is visited last, so the previous owner has lowest priority.
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(rr_last) + i) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uk_lookup_arbiter.sv
// Shares the single Uk coefficient ROM port between NREQ lanes: arbitrate, issue,
// wait ROM_LAT cycles, return the coefficient. Optional UK_ARB_BURST_EN macro.
module uk_lookup_arbiter
  import uk_arb_pkg::*;
#(
  parameter int NREQ    = UK_NREQ,
  parameter int AW      = UK_AW,
  parameter int DW      = UK_DW,
  parameter int ROM_LAT = 1
) (
  input  logic            CS,
  input  logic            cen,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            busy,
  output logic [AW-1:0]   rom_add,
  output logic            rom_en,
  input  logic [DW-1:0]   rom_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_last_q;
  logic [IW-1:0] winner;
  logic          any_req;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] rom_add_q;
  logic [DW-1:0] rsp_data_q;
`ifdef UK_ARB_BURST_EN
  logic [1:0]    burst_q;
  logic          burst_go;
`endif

  uk_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign rom_add  = rom_add_q;
  assign rsp_data = rsp_data_q;

  // NOTE: every output and next-state is given a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    rsp_valid = '0;
    rom_en    = 1'b0;
    busy      = (state_q != IDLE);
`ifdef UK_ARB_BURST_EN
    burst_go  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) state_d = ISSUE;
      end
      ISSUE: begin
        gnt[owner_q] = 1'b1;
        rom_en       = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        rom_en = 1'b1;
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
`ifdef UK_ARB_BURST_EN
        if (req[owner_q] && (burst_q < 2'(BURST_MAX - 1))) begin
          burst_go = 1'b1;
          state_d  = ISSUE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CS or negedge cen) begin
    if (!cen) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CS or negedge cen) begin
    if (!cen) begin
      owner_q    <= '0;
      rr_last_q  <= IW'(NREQ - 1);
      cnt_q      <= '0;
      rom_add_q  <= '0;
      rsp_data_q <= '0;
`ifdef UK_ARB_BURST_EN
      burst_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q   <= winner;
            rom_add_q <= req_addr[int'(winner)*AW +: AW];
`ifdef UK_ARB_BURST_EN
            burst_q   <= '0;
`endif
          end
        end
        ISSUE: begin
          cnt_q <= CW'(ROM_LAT - 1);
`ifndef UK_ARB_BURST_EN
          rr_last_q <= owner_q;
`endif
        end
        WAIT: begin
          if (cnt_q == '0) rsp_data_q <= rom_data;
          else             cnt_q      <= cnt_q - CW'(1);
        end
        RESP: begin
`ifdef UK_ARB_BURST_EN
          // Priority only rotates once the owner's burst is over.
          if (burst_go) begin
            rom_add_q <= req_addr[int'(owner_q)*AW +: AW];
            burst_q   <= burst_q + 2'd1;
          end else begin
            rr_last_q <= owner_q;
          end
`else
          rsp_data_q <= rsp_data_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uk_lookup_arbiter.sv
// Self-checking bench for uk_lookup_arbiter: ROM_LAT=1 instance for function and
// fairness, ROM_LAT=3 instance for the latency sweep; burst sequence under UK_ARB_BURST_EN.
module tb_uk_lookup_arbiter;
  import uk_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
`ifdef UK_ARB_BURST_EN
  localparam int RUN = BURST_MAX;
`else
  localparam int RUN = 1;
`endif

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    int            lane;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  logic              CS  = 1'b0;
  logic              cen = 1'b0;
  logic [NREQ-1:0]   req  = '0;
  logic [NREQ-1:0]   keep = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              busy, rom_en;
  logic [AW-1:0]     rom_add;
  logic [DW-1:0]     rom_data = '0;

  logic [NREQ-1:0]   req3 = '0;
  logic [NREQ*AW-1:0] req_addr3 = '0;
  logic [NREQ-1:0]   gnt3, rsp_valid3;
  logic [DW-1:0]     rsp_data3;
  logic              busy3, rom_en3;
  logic [AW-1:0]     rom_add3;
  logic [DW-1:0]     p0 = '0, p1 = '0, p2 = '0;

  exp_t sb[$];
  exp_t sb3[$];
  int   gnt_lane_q[$];
  int   gnt_cyc_q[$];
  int   rsp_cyc_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   rom_en3_cnt = 0;
  int   g3_lane = -1, g3_cyc = 0, r3_cyc = 0;
  vec_t vecs[8];

  uk_lookup_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(1)) dut (
    .CS(CS), .cen(cen), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .rom_add(rom_add), .rom_en(rom_en), .rom_data(rom_data)
  );

  uk_lookup_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(3)) dut3 (
    .CS(CS), .cen(cen), .req(req3), .req_addr(req_addr3), .gnt(gnt3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .busy(busy3),
    .rom_add(rom_add3), .rom_en(rom_en3), .rom_data(p2)
  );

  always #5 CS = ~CS;

  // Stand-in Uk table: 0 at address 0, 0x02 for the low band, a hash above.
  function automatic logic [DW-1:0] uk_coef(input logic [AW-1:0] a);
    if (a == '0)   return '0;
    if (a < 8'h20) return 8'h02;
    return a ^ 8'h5A;
  endfunction

  always @(posedge CS) if (rom_en) rom_data <= uk_coef(rom_add);

  always @(posedge CS) begin
    if (rom_en3) p0 <= uk_coef(rom_add3);
    p1 <= p0;
    p2 <= p1;
  end

  function automatic int lane_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Single observation point: one cycle, sampled just after the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge CS);
    #1;
    cyc++;
    if (cen) begin
      if (busy)    busy_cnt++;
      if (rom_en3) rom_en3_cnt++;
      if (gnt != '0) begin
        check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        check("gnt_rsp_overlap", 32'(rsp_valid), 32'd0);
        gnt_lane_q.push_back(lane_of(gnt));
        gnt_cyc_q.push_back(cyc);
        req = req & (~gnt | keep);
      end
      if (rsp_valid != '0) begin
        rsp_cyc_q.push_back(cyc);
        if (sb.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check("rsp_lane", 32'(rsp_valid), 32'd1 << e.lane);
          check("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
      if (gnt3 != '0) begin
        g3_lane = lane_of(gnt3);
        g3_cyc  = cyc;
        req3    = req3 & ~gnt3;
      end
      if (rsp_valid3 != '0) begin
        r3_cyc = cyc;
        if (sb3.size() == 0) check("rsp3_unexpected", 32'(rsp_valid3), 32'd0);
        else begin
          e = sb3.pop_front();
          check("rsp3_lane", 32'(rsp_valid3), 32'd1 << e.lane);
          check("rsp3_data", 32'(rsp_data3), 32'(e.data));
        end
      end
    end
  endtask

  task automatic set_addr(input int lane, input logic [AW-1:0] a);
    req_addr[lane*AW +: AW] = a;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while ((sb.size() != 0 || busy || req != '0) && n < bound) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n >= bound), 32'd0);
    if (n >= bound) begin
      sb.delete();
      req  = '0;
      keep = '0;
    end
  endtask

  task automatic wait_gnts(input string name, input int target, input int bound);
    int n = 0;
    while (gnt_lane_q.size() < target && n < bound) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n >= bound), 32'd0);
  endtask

  initial begin
    int base, b0, n, c3;
    vecs[0] = '{0, 8'h05, 8'h02};
    vecs[1] = '{1, 8'h00, 8'h00};
    vecs[2] = '{2, 8'h37, 8'h6D};
    vecs[3] = '{3, 8'hC4, 8'h9E};
    vecs[4] = '{0, 8'hFF, 8'hA5};
    vecs[5] = '{2, 8'h80, 8'hDA};
    vecs[6] = '{1, 8'h20, 8'h7A};
    vecs[7] = '{3, 8'h5A, 8'h00};

    // Reset values
    cen = 1'b0;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rom_add", 32'(rom_add), 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    cen = 1'b1;
    tick();

    // Reset asserted during WAIT of a lane-2 lookup drops it silently
    base = gnt_lane_q.size();
    set_addr(2, 8'h44);
    req[2] = 1'b1;
    wait_gnts("midrst_gnt", base + 1, 10);
    tick();
    check("midrst_pre_rom_en", 32'(rom_en), 32'd1);
    check("midrst_pre_rom_add", 32'(rom_add), 32'h44);
    cen = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rom_en", 32'(rom_en), 32'd0);
    check("midrst_rom_add", 32'(rom_add), 32'd0);
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);
    req = '0;
    tick();
    cen = 1'b1;
    base = rsp_cyc_q.size();
    repeat (6) tick();
    check("midrst_no_rsp", 32'(rsp_cyc_q.size() - base), 32'd0);

    // First arbitration after reset favours lane 0 over lane 3
    base = gnt_lane_q.size();
    set_addr(0, 8'h05);
    set_addr(3, 8'h20);
    sb.push_back('{0, 8'h02});
    sb.push_back('{3, 8'h7A});
    req[0] = 1'b1;
    req[3] = 1'b1;
    wait_done("post_rst", 40);
    check("post_rst_first", 32'(gnt_lane_q[base]), 32'd0);
    check("post_rst_second", 32'(gnt_lane_q[base + 1]), 32'd3);
    check("post_rst_latency", 32'(rsp_cyc_q[rsp_cyc_q.size() - 2] - gnt_cyc_q[base]), 32'd2);

    // Table vectors: single-lane lookups
    for (int i = 0; i < 8; i++) begin
      b0 = busy_cnt;
      set_addr(vecs[i].lane, vecs[i].addr);
      sb.push_back('{vecs[i].lane, vecs[i].data});
      req[vecs[i].lane] = 1'b1;
      wait_done($sformatf("vec%0d", i), 20);
      check($sformatf("vec%0d_gnt_lane", i), 32'(gnt_lane_q[$]), 32'(vecs[i].lane));
      check($sformatf("vec%0d_latency", i), 32'(rsp_cyc_q[$] - gnt_cyc_q[$]), 32'd2);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt - b0), 32'd3);
    end

    // Fairness: all lanes hold requests for 12 grants
    base = gnt_lane_q.size();
    for (int l = 0; l < NREQ; l++) set_addr(l, 8'(8'h10 + l));
    for (int k = 0; k < 12; k++) sb.push_back('{(k / RUN) % NREQ, 8'h02});
    keep = '1;
    req  = '1;
    wait_gnts("fair_gnts", base + 12, 200);
    req  = '0;
    keep = '0;
    wait_done("fair", 40);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("fair_order%0d", k), 32'(gnt_lane_q[base + k]), 32'((k / RUN) % NREQ));
      if (k > 0)
        check($sformatf("fair_spacing%0d", k),
              32'(gnt_cyc_q[base + k] - gnt_cyc_q[base + k - 1]),
              ((k % RUN) != 0) ? 32'd3 : 32'd4);
    end

    // Early drop: lane 3 releases req right after its grant
    c3 = 0;
    foreach (gnt_lane_q[k]) if (gnt_lane_q[k] == 3) c3++;
    set_addr(3, 8'h5A);
    sb.push_back('{3, 8'h00});
    req[3] = 1'b1;
    wait_done("early_drop", 20);
    repeat (8) tick();
    n = 0;
    foreach (gnt_lane_q[k]) if (gnt_lane_q[k] == 3) n++;
    check("early_drop_lane3_grants", 32'(n - c3), 32'd1);

    // Latency sweep on the ROM_LAT=3 instance
    for (int t = 0; t < 2; t++) begin
      int lane = t + 1;
      logic [AW-1:0] a;
      a = (t == 0) ? 8'h77 : 8'hE1;
      b0 = rom_en3_cnt;
      req_addr3[lane*AW +: AW] = a;
      sb3.push_back('{lane, (t == 0) ? 8'h2D : 8'hBB});
      req3[lane] = 1'b1;
      n = 0;
      while ((sb3.size() != 0 || busy3) && n < 30) begin
        tick();
        n++;
      end
      check($sformatf("lat3_%0d_timeout", t), 32'(n >= 30), 32'd0);
      check($sformatf("lat3_%0d_gnt_lane", t), 32'(g3_lane), 32'(lane));
      check($sformatf("lat3_%0d_latency", t), 32'(r3_cyc - g3_cyc), 32'd4);
      check($sformatf("lat3_%0d_rom_en_cycles", t), 32'(rom_en3_cnt - b0), 32'd4);
    end

`ifdef UK_ARB_BURST_EN
    // Burst: lane 0 holds req while lane 1 waits
    base = gnt_lane_q.size();
    set_addr(0, 8'h30);
    set_addr(1, 8'h05);
    for (int k = 0; k < BURST_MAX; k++) sb.push_back('{0, 8'h6A});
    sb.push_back('{1, 8'h02});
    keep[0] = 1'b1;
    req[0]  = 1'b1;
    req[1]  = 1'b1;
    wait_gnts("burst_gnts", base + BURST_MAX, 60);
    req[0]  = 1'b0;
    keep[0] = 1'b0;
    wait_done("burst", 40);
    for (int k = 0; k <= BURST_MAX; k++) begin
      check($sformatf("burst_order%0d", k), 32'(gnt_lane_q[base + k]), (k < BURST_MAX) ? 32'd0 : 32'd1);
      if (k > 0)
        check($sformatf("burst_spacing%0d", k),
              32'(gnt_cyc_q[base + k] - gnt_cyc_q[base + k - 1]),
              (k < BURST_MAX) ? 32'd3 : 32'd4);
    end
`endif

    check("sb_drained", 32'(sb.size() + sb3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
